// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: owner and FSM encodings, starve counter width.
package mem_bus_pkg;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_DBG,
      OWN_DBUS,
      OWN_IBUS
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the shared SoC bus; the arbiter takes the slave view.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cpu_en;

   logic            dbg_mem_op;
   logic            dbg_rw;
   logic [AW-1:0]   dbg_adr;
   logic [DW-1:0]   dbg_do;
   logic            dbg_mem_rdy;
   logic [DW-1:0]   dbg_di;

   logic            dcmd_valid;
   logic            dcmd_wr;
   logic [DW/8-1:0] dcmd_mask;
   logic [AW-1:0]   dcmd_adr;
   logic [DW-1:0]   dcmd_data;
   logic            dcmd_ready;
   logic            drsp_valid;
   logic [DW-1:0]   drsp_data;

   logic            icmd_valid;
   logic [AW-1:0]   icmd_adr;
   logic            icmd_ready;
   logic            irsp_valid;
   logic [DW-1:0]   irsp_data;

   logic            mem_op;
   logic [AW-1:0]   mem_adr;
   logic [DW/8-1:0] mem_wren;
   logic [DW-1:0]   mem_di;
   logic [DW-1:0]   mem_do;

   modport slave (
      input  cpu_en,
      input  dbg_mem_op, dbg_rw, dbg_adr, dbg_do,
      output dbg_mem_rdy, dbg_di,
      input  dcmd_valid, dcmd_wr, dcmd_mask, dcmd_adr, dcmd_data,
      output dcmd_ready, drsp_valid, drsp_data,
      input  icmd_valid, icmd_adr,
      output icmd_ready, irsp_valid, irsp_data,
      output mem_op, mem_adr, mem_wren, mem_di,
      input  mem_do
   );

   modport master (
      output cpu_en,
      output dbg_mem_op, dbg_rw, dbg_adr, dbg_do,
      input  dbg_mem_rdy, dbg_di,
      output dcmd_valid, dcmd_wr, dcmd_mask, dcmd_adr, dcmd_data,
      input  dcmd_ready, drsp_valid, drsp_data,
      output icmd_valid, icmd_adr,
      input  icmd_ready, irsp_valid, irsp_data,
      input  mem_op, mem_adr, mem_wren, mem_di,
      output mem_do
   );

endinterface

// File: rtl/mem_bus_pick.sv
// Combinational owner picker: dbg > dbus > ibus, ibus jumps dbus once starved.
// Zero latency; candidates arrive already qualified by FSM state and cpu_en.
module mem_bus_pick
   import mem_bus_pkg::*;
(
   input  logic   dbg_i,
   input  logic   dbus_i,
   input  logic   ibus_i,
   input  logic   starve_i,
   output owner_e owner_o
);

   always_comb begin
      owner_o = OWN_NONE;
      if (dbg_i) begin
         owner_o = OWN_DBG;
      end else if (ibus_i && (starve_i || !dbus_i)) begin
         owner_o = OWN_IBUS;
      end else if (dbus_i) begin
         owner_o = OWN_DBUS;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-way arbiter for the SoC memory bus: accept cycle N, bus access N+1, response pulse N+2.
// Accept pulses only in IDLE/RESP cycles, so at most one access every two cycles.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW                = 32,
   parameter int DW                = 32,
   parameter int IBUS_STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   mem_bus_arbiter_if.slave  bus
);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [AW-1:0]       adr_q, adr_d;
   logic [DW-1:0]       di_q, di_d;
   logic [DW/8-1:0]     wren_q, wren_d;
   logic                rd_q, rd_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic   arb_en;
   logic   cand_dbg;
   logic   cand_dbus;
   logic   cand_ibus;
   logic   starve_hit;
   logic   acc;
   logic   rsp;
   owner_e win;

   assign arb_en     = n_reset && (state_q != S_ACCESS);
   // The debug request stays high through its own response cycle; it must not re-win there.
   assign cand_dbg   = arb_en && bus.dbg_mem_op && !(state_q == S_RESP && owner_q == OWN_DBG);
   assign cand_dbus  = arb_en && bus.cpu_en && bus.dcmd_valid;
   assign cand_ibus  = arb_en && bus.cpu_en && bus.icmd_valid;
   assign starve_hit = (starve_q == STARVE_W'(IBUS_STARVE_LIMIT));

   mem_bus_pick u_pick (
      .dbg_i    (cand_dbg),
      .dbus_i   (cand_dbus),
      .ibus_i   (cand_ibus),
      .starve_i (starve_hit),
      .owner_o  (win)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      adr_d    = adr_q;
      di_d     = di_q;
      wren_d   = wren_q;
      rd_d     = rd_q;
      starve_d = starve_q;

      unique case (state_q)
         S_IDLE:   if (win != OWN_NONE) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = (win != OWN_NONE) ? S_ACCESS : S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) owner_d = OWN_NONE;

      unique case (win)
         OWN_DBG: begin
            owner_d = OWN_DBG;
            adr_d   = bus.dbg_adr;
            di_d    = bus.dbg_do;
            wren_d  = bus.dbg_rw ? '0 : '1;
            rd_d    = bus.dbg_rw;
         end
         OWN_DBUS: begin
            owner_d = OWN_DBUS;
            adr_d   = bus.dcmd_adr;
            di_d    = bus.dcmd_data;
            wren_d  = bus.dcmd_wr ? bus.dcmd_mask : '0;
            rd_d    = !bus.dcmd_wr;
         end
         OWN_IBUS: begin
            owner_d = OWN_IBUS;
            adr_d   = bus.icmd_adr;
            di_d    = '0;
            wren_d  = '0;
            rd_d    = 1'b1;
         end
         default: ;
      endcase

      if (!bus.icmd_valid || win == OWN_IBUS) begin
         starve_d = '0;
      end else if (win == OWN_DBUS && bus.cpu_en && !starve_hit) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_NONE;
         adr_q    <= '0;
         di_q     <= '0;
         wren_q   <= '0;
         rd_q     <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         adr_q    <= adr_d;
         di_q     <= di_d;
         wren_q   <= wren_d;
         rd_q     <= rd_d;
         starve_q <= starve_d;
      end
   end

   assign acc = (state_q == S_ACCESS);
   assign rsp = (state_q == S_RESP);

   // Address and data are forced to zero off the access cycle to keep the OR-bus clean.
   assign bus.mem_op   = acc;
   assign bus.mem_adr  = acc ? adr_q  : '0;
   assign bus.mem_wren = acc ? wren_q : '0;
   assign bus.mem_di   = acc ? di_q   : '0;

   assign bus.dcmd_ready = (win == OWN_DBUS);
   assign bus.icmd_ready = (win == OWN_IBUS);

   assign bus.dbg_mem_rdy = rsp && (owner_q == OWN_DBG);
   assign bus.dbg_di      = bus.dbg_mem_rdy ? bus.mem_do : '0;
   assign bus.drsp_valid  = rsp && (owner_q == OWN_DBUS) && rd_q;
   assign bus.drsp_data   = bus.drsp_valid ? bus.mem_do : '0;
   assign bus.irsp_valid  = rsp && (owner_q == OWN_IBUS);
   assign bus.irsp_data   = bus.irsp_valid ? bus.mem_do : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_bus_arbiter;

   logic clk;
   logic n_reset;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_bus_arbiter #(
      .AW                (32),
      .DW                (32),
      .IBUS_STARVE_LIMIT (4)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.dbg_mem_op = 1'b0;
      bus.dbg_rw     = 1'b0;
      bus.dbg_adr    = '0;
      bus.dbg_do     = '0;
      bus.dcmd_valid = 1'b0;
      bus.dcmd_wr    = 1'b0;
      bus.dcmd_mask  = '0;
      bus.dcmd_adr   = '0;
      bus.dcmd_data  = '0;
      bus.icmd_valid = 1'b0;
      bus.icmd_adr   = '0;
   endtask

   task automatic idle(input int n);
      clr();
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_op"},  32'(bus.mem_op), 0);
      chk({tag, "_mem_adr"}, bus.mem_adr, 0);
      chk({tag, "_mem_wren"}, 32'(bus.mem_wren), 0);
      chk({tag, "_mem_di"},  bus.mem_di, 0);
      chk({tag, "_drsp"},    32'(bus.drsp_valid), 0);
      chk({tag, "_drsp_dat"}, bus.drsp_data, 0);
      chk({tag, "_irsp"},    32'(bus.irsp_valid), 0);
      chk({tag, "_dbg_rdy"}, 32'(bus.dbg_mem_rdy), 0);
   endtask

   initial begin
      n_reset    = 1'b0;
      bus.cpu_en = 1'b1;
      bus.mem_do = 32'hFFFF_FFFF;
      clr();
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h1234;

      // Reset: everything quiet, no ready even with a valid request present
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_irdy", 32'(bus.icmd_ready), 0);
      chk("rst_drdy", 32'(bus.dcmd_ready), 0);
      step();
      n_reset = 1'b1;
      clr();

      // Single ibus fetch at 0x20004
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h20004;
      bus.mem_do     = 32'h0000_0013;
      @(negedge clk);
      chk("t1_c0_irdy", 32'(bus.icmd_ready), 1);
      chk("t1_c0_mem_op", 32'(bus.mem_op), 0);
      step();
      clr();
      @(negedge clk);
      chk("t1_c1_mem_op", 32'(bus.mem_op), 1);
      chk("t1_c1_adr", bus.mem_adr, 32'h20004);
      chk("t1_c1_wren", 32'(bus.mem_wren), 0);
      chk("t1_c1_irsp", 32'(bus.irsp_valid), 0);
      step();
      @(negedge clk);
      chk("t1_c2_irsp", 32'(bus.irsp_valid), 1);
      chk("t1_c2_idat", bus.irsp_data, 32'h0000_0013);
      chk("t1_c2_ddat", bus.drsp_data, 0);
      chk("t1_c2_mem_op", 32'(bus.mem_op), 0);
      chk("t1_c2_adr", bus.mem_adr, 0);
      step();
      @(negedge clk);
      chk("t1_c3_irsp", 32'(bus.irsp_valid), 0);
      idle(1);

      // dbus write: mask 0011, drsp_valid must never fire
      bus.dcmd_valid = 1'b1;
      bus.dcmd_wr    = 1'b1;
      bus.dcmd_mask  = 4'b0011;
      bus.dcmd_adr   = 32'h10;
      bus.dcmd_data  = 32'hAABB_CCDD;
      @(negedge clk);
      chk("t2_c0_drdy", 32'(bus.dcmd_ready), 1);
      step();
      clr();
      @(negedge clk);
      chk("t2_c1_mem_op", 32'(bus.mem_op), 1);
      chk("t2_c1_adr", bus.mem_adr, 32'h10);
      chk("t2_c1_wren", 32'(bus.mem_wren), 32'h3);
      chk("t2_c1_di", bus.mem_di, 32'hAABB_CCDD);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t2_drsp_%0d", c + 1), 32'(bus.drsp_valid), 0);
         step();
         @(negedge clk);
      end
      idle(1);

      // dbg read, dbus read and ibus fetch all presented at once
      bus.mem_do     = 32'hDEAD_BEEF;
      bus.dbg_mem_op = 1'b1;
      bus.dbg_rw     = 1'b1;
      bus.dbg_adr    = 32'h100;
      bus.dcmd_valid = 1'b1;
      bus.dcmd_adr   = 32'h200;
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h300;
      @(negedge clk);
      chk("t3_c0_drdy", 32'(bus.dcmd_ready), 0);
      chk("t3_c0_irdy", 32'(bus.icmd_ready), 0);
      step();
      @(negedge clk);
      chk("t3_c1_adr", bus.mem_adr, 32'h100);
      chk("t3_c1_wren", 32'(bus.mem_wren), 0);
      step();
      @(negedge clk);
      chk("t3_c2_dbg_rdy", 32'(bus.dbg_mem_rdy), 1);
      chk("t3_c2_dbg_di", bus.dbg_di, 32'hDEAD_BEEF);
      chk("t3_c2_drdy", 32'(bus.dcmd_ready), 1);
      chk("t3_c2_irdy", 32'(bus.icmd_ready), 0);
      step();
      bus.dbg_mem_op = 1'b0;
      bus.dcmd_valid = 1'b0;
      @(negedge clk);
      chk("t3_c3_adr", bus.mem_adr, 32'h200);
      chk("t3_c3_dbg_rdy", 32'(bus.dbg_mem_rdy), 0);
      step();
      @(negedge clk);
      chk("t3_c4_drsp", 32'(bus.drsp_valid), 1);
      chk("t3_c4_ddat", bus.drsp_data, 32'hDEAD_BEEF);
      chk("t3_c4_dbg_di", bus.dbg_di, 0);
      chk("t3_c4_irdy", 32'(bus.icmd_ready), 1);
      step();
      bus.icmd_valid = 1'b0;
      @(negedge clk);
      chk("t3_c5_adr", bus.mem_adr, 32'h300);
      step();
      @(negedge clk);
      chk("t3_c6_irsp", 32'(bus.irsp_valid), 1);
      idle(2);

      // Continuous dbus + ibus: four dbus grants, then ibus forced, then dbus again
      bus.dcmd_valid = 1'b1;
      bus.dcmd_adr   = 32'h40;
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h80;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("t4_c%0d_drdy", c), 32'(bus.dcmd_ready),
             32'(c == 0 || c == 2 || c == 4 || c == 6 || c == 10));
         chk($sformatf("t4_c%0d_irdy", c), 32'(bus.icmd_ready), 32'(c == 8));
         chk($sformatf("t4_c%0d_adr", c), bus.mem_adr,
             (c == 9) ? 32'h80 : ((c % 2 == 1) ? 32'h40 : 32'h0));
         step();
      end
      idle(3);

      // cpu_en low for 10 cycles with ibus waiting; a debug write slips through
      bus.cpu_en     = 1'b0;
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h900;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            bus.dbg_mem_op = 1'b1;
            bus.dbg_rw     = 1'b0;
            bus.dbg_adr    = 32'h500;
            bus.dbg_do     = 32'h1234_5678;
         end
         @(negedge clk);
         chk($sformatf("t5_c%0d_irdy", c), 32'(bus.icmd_ready), 0);
         chk($sformatf("t5_c%0d_mem_op", c), 32'(bus.mem_op), 32'(c == 4));
         chk($sformatf("t5_c%0d_dbg_rdy", c), 32'(bus.dbg_mem_rdy), 32'(c == 5));
         if (c == 4) begin
            chk("t5_c4_wren", 32'(bus.mem_wren), 32'hF);
            chk("t5_c4_di", bus.mem_di, 32'h1234_5678);
            chk("t5_c4_adr", bus.mem_adr, 32'h500);
         end
         step();
         if (c == 5) bus.dbg_mem_op = 1'b0;
      end
      bus.cpu_en = 1'b1;
      @(negedge clk);
      chk("t5_c10_irdy", 32'(bus.icmd_ready), 1);
      step();
      bus.icmd_valid = 1'b0;
      @(negedge clk);
      chk("t5_c11_adr", bus.mem_adr, 32'h900);
      step();
      @(negedge clk);
      chk("t5_c12_irsp", 32'(bus.irsp_valid), 1);
      idle(2);

      // Reset lands during the access cycle of a dbus read
      bus.mem_do     = 32'h5555_AAAA;
      bus.dcmd_valid = 1'b1;
      bus.dcmd_wr    = 1'b0;
      bus.dcmd_adr   = 32'h600;
      @(negedge clk);
      chk("t6_c0_drdy", 32'(bus.dcmd_ready), 1);
      step();
      clr();
      n_reset = 1'b0;
      @(negedge clk);
      chk("t6_c1_mem_op", 32'(bus.mem_op), 1);
      chk("t6_c1_adr", bus.mem_adr, 32'h600);
      step();
      n_reset = 1'b1;
      @(negedge clk);
      chk_quiet("t6_c2");
      step();
      @(negedge clk);
      chk("t6_c3_drsp", 32'(bus.drsp_valid), 0);
      step();
      bus.mem_do     = 32'h0000_0077;
      bus.icmd_valid = 1'b1;
      bus.icmd_adr   = 32'h700;
      @(negedge clk);
      chk("t6_c4_irdy", 32'(bus.icmd_ready), 1);
      step();
      clr();
      @(negedge clk);
      chk("t6_c5_adr", bus.mem_adr, 32'h700);
      step();
      @(negedge clk);
      chk("t6_c6_irsp", 32'(bus.irsp_valid), 1);
      chk("t6_c6_idat", bus.irsp_data, 32'h0000_0077);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
